// File: rtl/program_loader_if.sv
// ---------------------------------------------------------------------------
// program_loader_if
// Byte-stream handshake carrying the boot image into the program loader.
//   s_valid : producer has a byte on s_data
//   s_data  : byte value
//   s_ready : loader can accept a byte this cycle
// A byte moves only on a cycle where s_valid and s_ready are both 1.
// Modports:
//   master : the byte producer (UART/JTAG bridge, testbench)
//   slave  : the loader
// ---------------------------------------------------------------------------
interface program_loader_if;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/program_loader.sv
// ---------------------------------------------------------------------------
// program_loader
// Receives a byte stream and writes it as 32-bit words into the instruction
// or data BRAM, holding the CPU in stall until a start command arrives.
//
// Stream format:
//   0x01 | 0x02, count_lo, count_hi, count x (4 bytes little-endian word)
//     0x01 targets instruction BRAM, 0x02 targets data BRAM; every segment
//     starts at byte address 0.
//   0x03 : release the CPU (terminal until reset).
//   anything else in command position : sticky error (terminal until reset).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous reset, active low
//   s          byte-stream slave (s_valid, s_data, s_ready)
//   i_w_addr   instruction BRAM byte address (word_index*4, 10 bit)
//   i_w_dat    instruction BRAM write data
//   i_w_enb    instruction BRAM write enable (one cycle per word)
//   d_w_addr   data BRAM byte address
//   d_w_dat    data BRAM write data
//   d_w_enb    data BRAM write enable
//   cpu_stall  1 holds the core; 0 only in RUN
//   load_err   sticky protocol error
// ---------------------------------------------------------------------------
module program_loader #(
  parameter int I_DEPTH_WORDS = 256,
  parameter int D_DEPTH_WORDS = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  program_loader_if.slave         s,
  output logic [9:0]              i_w_addr,
  output logic [31:0]             i_w_dat,
  output logic                    i_w_enb,
  output logic [9:0]              d_w_addr,
  output logic [31:0]             d_w_dat,
  output logic                    d_w_enb,
  output logic                    cpu_stall,
  output logic                    load_err
);

  localparam logic [31:0] I_DEPTH = 32'(I_DEPTH_WORDS);
  localparam logic [31:0] D_DEPTH = 32'(D_DEPTH_WORDS);

  localparam logic [7:0] CMD_INSTR = 8'h01;
  localparam logic [7:0] CMD_DATA  = 8'h02;
  localparam logic [7:0] CMD_START = 8'h03;

  typedef enum logic [2:0] {
    IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN, ERROR
  } state_t;

  typedef enum logic {
    TGT_INSTR, TGT_DATA
  } target_t;

  state_t      state, next_state;
  target_t     target;
  logic [7:0]  len_lo;
  logic [15:0] count;
  logic [15:0] word_idx;
  logic [1:0]  byte_cnt;
  logic [31:0] word_buf;

  logic        take;
  logic [15:0] len_full;
  logic        len_too_big;
  logic [31:0] word_full;
  logic [9:0]  word_addr;

  assign take      = s.s_valid & s.s_ready;
  assign len_full  = {s.s_data, len_lo};
  assign word_full = {s.s_data, word_buf[31:8]};
  // Byte address of the current word; upper index bits fall off by design.
  assign word_addr = {word_idx[7:0], 2'b00};

  always_comb begin
    len_too_big = (target == TGT_INSTR) ? (32'(len_full) > I_DEPTH)
                                        : (32'(len_full) > D_DEPTH);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    s.s_ready  = 1'b0;
    cpu_stall  = 1'b1;
    load_err   = 1'b0;

    unique case (state)
      IDLE: begin
        s.s_ready = rst;
        if (take) begin
          if (s.s_data == CMD_INSTR || s.s_data == CMD_DATA) next_state = LEN_LO;
          else if (s.s_data == CMD_START)                     next_state = RUN;
          else                                                next_state = ERROR;
        end
      end
      LEN_LO: begin
        s.s_ready = rst;
        if (take) next_state = LEN_HI;
      end
      LEN_HI: begin
        s.s_ready = rst;
        if (take) begin
          if (len_full == 16'd0) next_state = IDLE;
          else if (len_too_big)  next_state = ERROR;
          else                   next_state = DATA;
        end
      end
      DATA: begin
        s.s_ready = rst;
        if (take && byte_cnt == 2'd3) next_state = WRITE;
      end
      WRITE: begin
        next_state = (word_idx + 16'd1 == count) ? IDLE : DATA;
      end
      RUN: begin
        cpu_stall = 1'b0;
      end
      ERROR: begin
        load_err = 1'b1;
      end
      default: next_state = ERROR;
    endcase
  end

  // NOTE: reset is synchronous and active low, so it lives inside the
  // clocked block and is simply the highest-priority branch.
  always_ff @(posedge clk) begin
    if (!rst) begin
      target   <= TGT_INSTR;
      len_lo   <= '0;
      count    <= '0;
      word_idx <= '0;
      byte_cnt <= '0;
      word_buf <= '0;
      i_w_addr <= '0;
      i_w_dat  <= '0;
      i_w_enb  <= 1'b0;
      d_w_addr <= '0;
      d_w_dat  <= '0;
      d_w_enb  <= 1'b0;
    end else begin
      i_w_enb <= 1'b0;
      d_w_enb <= 1'b0;

      unique case (state)
        IDLE: begin
          if (take && s.s_data == CMD_INSTR) target <= TGT_INSTR;
          if (take && s.s_data == CMD_DATA)  target <= TGT_DATA;
        end
        LEN_LO: begin
          if (take) len_lo <= s.s_data;
        end
        LEN_HI: begin
          if (take) begin
            count    <= len_full;
            word_idx <= '0;
            byte_cnt <= '0;
          end
        end
        DATA: begin
          if (take) begin
            // Shift in from the top: after four bytes the first one sits in [7:0].
            word_buf <= word_full;
            byte_cnt <= byte_cnt + 2'd1;
            // Enables are registered on the 4th byte so they are high exactly
            // during the single WRITE cycle; addr/dat hold otherwise.
            if (byte_cnt == 2'd3) begin
              if (target == TGT_INSTR) begin
                i_w_addr <= word_addr;
                i_w_dat  <= word_full;
                i_w_enb  <= 1'b1;
              end else begin
                d_w_addr <= word_addr;
                d_w_dat  <= word_full;
                d_w_enb  <= 1'b1;
              end
            end
          end
        end
        WRITE: begin
          word_idx <= word_idx + 16'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter I_DEPTH_WORDS, default 256, meaning max words accepted for instruction BRAM.
REQ-002 SHALL have parameter D_DEPTH_WORDS, default 256, meaning max words accepted for data BRAM.
REQ-003 SHALL use one clock and a synchronous active-low reset; ports listed below.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous reset, active-low (rst=0 resets on the next rising clk).
REQ-006 s_valid  input  1  byte-stream valid.
REQ-007 s_data  input  8  byte-stream data.
REQ-008 s_ready  output  1  loader can accept a byte.
REQ-009 i_w_addr  output  10  instruction BRAM byte write address.
REQ-010 i_w_dat  output  32  instruction BRAM write data.
REQ-011 i_w_enb  output  1  instruction BRAM write enable.
REQ-012 d_w_addr  output  10  data BRAM byte write address.
REQ-013 d_w_dat  output  32  data BRAM write data.
REQ-014 d_w_enb  output  1  data BRAM write enable.
REQ-015 cpu_stall  output  1  drives PC stall; 1 holds the core.
REQ-016 load_err  output  1  sticky protocol error flag.

Function
REQ-017 Byte transfer SHALL occur only on cycles where s_valid=1 and s_ready=1.
REQ-018 Protocol SHALL be: command byte; for 0x01 (instr) / 0x02 (data) then count low byte, count high byte, then count words of 4 bytes each, little-endian; 0x03 = start.
REQ-019 States SHALL be IDLE, LEN_LO, LEN_HI, DATA, WRITE, RUN, ERROR.
REQ-020 IDLE: accepted 0x01/0x02 -> LEN_LO, latch target; 0x03 -> RUN; any other byte -> ERROR.
REQ-021 LEN_LO -> LEN_HI on accepted byte; LEN_HI -> DATA on accepted byte, word index cleared to 0.
REQ-022 On LEN_HI completion, count=0 SHALL return to IDLE with no writes; count > target depth parameter SHALL go to ERROR with no writes.
REQ-023 DATA SHALL assemble bytes little-endian (first byte -> bits 7:0); 4th accepted byte -> WRITE.
REQ-024 WRITE SHALL last exactly one cycle: selected w_enb=1, w_dat=assembled word, w_addr=word_index*4 (10-bit, truncated); other target enb=0.
REQ-025 After WRITE: word index increments; if index+1 == count -> IDLE, else -> DATA.
REQ-026 Latency: 4th byte accepted in cycle N SHALL produce write enable in cycle N+1 only.
REQ-027 s_ready SHALL be 1 in IDLE, LEN_LO, LEN_HI, DATA; 0 in WRITE, RUN, ERROR.
REQ-028 Each 0x01/0x02 segment SHALL restart at address 0; a repeated segment overwrites earlier words.
REQ-029 cpu_stall SHALL be 1 in every state except RUN; RUN SHALL be terminal until reset.
REQ-030 ERROR SHALL set load_err=1, keep cpu_stall=1, ignore input; terminal until reset.
REQ-031 w_addr/w_dat SHALL hold their last values when enb=0.
REQ-032 s_valid toggling mid-word SHALL stall assembly without loss or duplication of bytes.

Reset
REQ-033 On rst=0 at a rising edge: state IDLE, s_ready=0 that cycle then 1 after release, i_w_enb=d_w_enb=0, addresses and data 0, word index 0, cpu_stall=1, load_err=0.
REQ-034 Reset mid-segment SHALL discard the partial word and issue no write; previously written BRAM contents are not the loader's responsibility.

Verification
REQ-035 Stream 01 03 00 + words 0x00500293,0xFFF00313,0x00800393 -> three i_w_enb pulses, addrs 0x000/0x004/0x008, matching data, d_w_enb never 1.
REQ-036 Stream 02 03 00 + 0x8,0xA,0xC then 03 -> d_w_enb at 0x0/0x4/0x8 with 8/A/C; cpu_stall falls to 0 the cycle after 0x03 accepted; s_ready=0 thereafter.
REQ-037 Command 0x07 -> load_err=1 next cycle, cpu_stall stays 1, no write enables, s_ready=0.
REQ-038 Stream 01 01 01 (count 257, I_DEPTH_WORDS=256) -> ERROR, zero writes.
REQ-039 Random s_valid gaps during 16-word instr load -> 16 writes, contiguous addresses 0x000..0x03C, exact data, no duplicates.
REQ-040 rst=0 after 2 data bytes of a word, then restart 01 01 00 + word -> single write at 0x000 with new word, load_err=0.
